// File: rtl/core_pkg.sv
// Shared core definitions: bubble encodings, register indices and the
// pipeline-controller state encoding. Also used by ifu_de and de_alu.
package core_pkg;

    // addi x0, x0, 0 -- loaded into ifu_de when it is flushed
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    // Hard-wired zero register index; never a real hazard source
    localparam logic [4:0]  REG_X0   = 5'd0;

    // Halt/drain/resume sequencing states of pipe_ctrl
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } ctrl_state_e;

    // True when a source operand reads the register a load is about to write
    function automatic logic src_hits_rd(input logic       use_en,
                                         input logic [4:0] src_addr,
                                         input logic [4:0] rd_addr);
        return use_en & (src_addr == rd_addr);
    endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_det.sv
// Load-use hazard comparator between the de and alu stages.
// Pure combinational; no state.
module pipe_ctrl_hazard_det
    import core_pkg::*;
(
    input  logic [4:0] de_rs1_addr_i,
    input  logic       de_rs1_use_i,
    input  logic [4:0] de_rs2_addr_i,
    input  logic       de_rs2_use_i,
    input  logic [4:0] ex_rd_addr_i,
    input  logic       ex_rd_en_i,
    input  logic       ex_is_load_i,
    output logic       luh_o
);

    logic ld_writes_s;
    logic src_hit_s;

    // A load writing a real register, and a de operand that reads it
    always_comb begin
        ld_writes_s = ex_is_load_i & ex_rd_en_i & (ex_rd_addr_i != REG_X0);
        src_hit_s   = src_hits_rd(de_rs1_use_i, de_rs1_addr_i, ex_rd_addr_i) |
                      src_hits_rd(de_rs2_use_i, de_rs2_addr_i, ex_rd_addr_i);
        luh_o       = ld_writes_s & src_hit_s;
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Central hazard and sequencing controller for the 5-stage core.
// Drives pipeline-register hold/flush controls and the ifu redirect port,
// and runs the debug halt/drain/resume sequence.
module pipe_ctrl
    import core_pkg::*;
#(
    parameter int          DRAIN_CYCLES = 3,
    parameter logic [31:0] RST_PC       = 32'h0000_0000,
    parameter int          CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       de_rs1_addr,
    input  logic             de_rs1_use,
    input  logic [4:0]       de_rs2_addr,
    input  logic             de_rs2_use,
    input  logic [4:0]       ex_rd_addr,
    input  logic             ex_rd_en,
    input  logic             ex_is_load,
    input  logic             ex_jump_en,
    input  logic [31:0]      ex_jump_addr,
    input  logic             halt_req,
    output logic             pc_hold,
    output logic             ifde_hold,
    output logic             ifde_flush,
    output logic             dealu_flush,
    output logic             redirect_en,
    output logic [31:0]      redirect_pc,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int            DW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

    ctrl_state_e      state_q, state_d;
    logic [DW-1:0]    drain_cnt_q, drain_cnt_d;
    logic             pend_valid_q, pend_valid_d;
    logic [31:0]      pend_pc_q, pend_pc_d;
    logic             rst_redir_q;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             stall_inc_s;
    logic             luh_s;

    pipe_ctrl_hazard_det u_hazard_det (
        .de_rs1_addr_i (de_rs1_addr),
        .de_rs1_use_i  (de_rs1_use),
        .de_rs2_addr_i (de_rs2_addr),
        .de_rs2_use_i  (de_rs2_use),
        .ex_rd_addr_i  (ex_rd_addr),
        .ex_rd_en_i    (ex_rd_en),
        .ex_is_load_i  (ex_is_load),
        .luh_o         (luh_s)
    );

    // State, drain counter, pending redirect, reset redirect flag and perf counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_RUN;
            drain_cnt_q  <= '0;
            pend_valid_q <= 1'b0;
            pend_pc_q    <= 32'h0000_0000;
            rst_redir_q  <= 1'b1;
            stall_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            drain_cnt_q  <= drain_cnt_d;
            pend_valid_q <= pend_valid_d;
            pend_pc_q    <= pend_pc_d;
            rst_redir_q  <= 1'b0;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    // Next-state logic and same-cycle hazard/sequencing decode
    always_comb begin
        state_d      = state_q;
        drain_cnt_d  = drain_cnt_q;
        pend_valid_d = pend_valid_q;
        pend_pc_d    = pend_pc_q;
        pc_hold      = 1'b0;
        ifde_hold    = 1'b0;
        ifde_flush   = 1'b0;
        dealu_flush  = 1'b0;
        redirect_en  = 1'b0;
        redirect_pc  = 32'h0000_0000;
        halted       = 1'b0;
        stall_inc_s  = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (halt_req) begin
                    // Discard the de instruction; it is re-fetched on resume
                    state_d     = ST_DRAIN;
                    drain_cnt_d = '0;
                    pc_hold     = 1'b1;
                    ifde_flush  = 1'b1;
                    dealu_flush = 1'b1;
                    stall_inc_s = 1'b1;
                    if (ex_jump_en) begin
                        pend_valid_d = 1'b1;
                        pend_pc_d    = ex_jump_addr;
                    end else begin
                        // Held ifu PC already points at the discarded instruction
                        pend_valid_d = 1'b0;
                    end
                end else if (ex_jump_en) begin
                    // The de instruction is flushed, so any luh on it is moot
                    redirect_en = 1'b1;
                    redirect_pc = ex_jump_addr;
                    ifde_flush  = 1'b1;
                    dealu_flush = 1'b1;
                end else if (luh_s) begin
                    pc_hold     = 1'b1;
                    ifde_hold   = 1'b1;
                    dealu_flush = 1'b1;
                    stall_inc_s = 1'b1;
                end else begin
                    pc_hold = 1'b0;
                end
            end
            ST_DRAIN: begin
                // Fetch stopped; let alu/lsu/wb retire. halt_req drop does not abort
                pc_hold     = 1'b1;
                ifde_flush  = 1'b1;
                dealu_flush = 1'b1;
                if (drain_cnt_q == DRAIN_LAST) begin
                    state_d     = ST_HALTED;
                    drain_cnt_d = '0;
                end else begin
                    drain_cnt_d = drain_cnt_q + DW'(1);
                end
            end
            ST_HALTED: begin
                halted      = 1'b1;
                pc_hold     = 1'b1;
                ifde_flush  = 1'b1;
                dealu_flush = 1'b1;
                if (!halt_req) begin
                    state_d     = ST_RUN;
                    drain_cnt_d = '0;
                    if (pend_valid_q) begin
                        redirect_en  = 1'b1;
                        redirect_pc  = pend_pc_q;
                        pend_valid_d = 1'b0;
                    end else begin
                        pend_valid_d = 1'b0;
                    end
                end else begin
                    state_d = ST_HALTED;
                end
            end
            default: begin
                state_d      = ST_RUN;
                drain_cnt_d  = '0;
                pend_valid_d = 1'b0;
            end
        endcase

        // The boot redirect to RST_PC wins over anything else on that cycle
        if (rst_redir_q) begin
            redirect_en = 1'b1;
            redirect_pc = RST_PC;
        end else begin
            redirect_en = redirect_en;
        end
    end

    // Performance counter advances on front-end stall cycles in RUN only
    always_comb begin
        if (stall_inc_s) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed, table-driven bench for pipe_ctrl.
module tb_pipe_ctrl;

    localparam logic [31:0] RST_PC_T = 32'h0000_0080;
    localparam int          CW       = 4;

    // Expected-flag encoding: {pc_hold, ifde_hold, ifde_flush, dealu_flush, redirect_en, halted}
    localparam logic [5:0] F_NONE  = 6'b000000;
    localparam logic [5:0] F_STALL = 6'b110100;
    localparam logic [5:0] F_JUMP  = 6'b001110;
    localparam logic [5:0] F_DRAIN = 6'b101100;
    localparam logic [5:0] F_HALT  = 6'b101101;
    localparam logic [5:0] F_HREL  = 6'b101111;
    localparam logic [5:0] F_RST   = 6'b000010;

    typedef struct {
        logic [4:0]    rs1;
        logic          u1;
        logic [4:0]    rs2;
        logic          u2;
        logic [4:0]    rd;
        logic          rd_en;
        logic          ld;
        logic          jmp;
        logic [31:0]   ja;
        logic          hreq;
        logic [5:0]    eflags;
        logic [31:0]   epc;
        logic [CW-1:0] ecnt;
    } vec_t;

    logic          clk;
    logic          rst;
    logic [4:0]    de_rs1_addr, de_rs2_addr, ex_rd_addr;
    logic          de_rs1_use, de_rs2_use, ex_rd_en, ex_is_load, ex_jump_en, halt_req;
    logic [31:0]   ex_jump_addr;
    logic          pc_hold, ifde_hold, ifde_flush, dealu_flush, redirect_en, halted;
    logic [31:0]   redirect_pc;
    logic [CW-1:0] stall_cnt;

    int n_chk;
    int n_fail;

    pipe_ctrl #(
        .DRAIN_CYCLES (3),
        .RST_PC       (RST_PC_T),
        .CNT_W        (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .de_rs1_addr  (de_rs1_addr),
        .de_rs1_use   (de_rs1_use),
        .de_rs2_addr  (de_rs2_addr),
        .de_rs2_use   (de_rs2_use),
        .ex_rd_addr   (ex_rd_addr),
        .ex_rd_en     (ex_rd_en),
        .ex_is_load   (ex_is_load),
        .ex_jump_en   (ex_jump_en),
        .ex_jump_addr (ex_jump_addr),
        .halt_req     (halt_req),
        .pc_hold      (pc_hold),
        .ifde_hold    (ifde_hold),
        .ifde_flush   (ifde_flush),
        .dealu_flush  (dealu_flush),
        .redirect_en  (redirect_en),
        .redirect_pc  (redirect_pc),
        .halted       (halted),
        .stall_cnt    (stall_cnt)
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(input logic [4:0] rs1, input logic u1,
                                input logic [4:0] rs2, input logic u2,
                                input logic [4:0] rd, input logic rd_en, input logic ld,
                                input logic jmp, input logic [31:0] ja, input logic hreq,
                                input logic [5:0] ef, input logic [31:0] epc,
                                input logic [CW-1:0] ecnt);
        vec_t v;
        v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
        v.rd = rd; v.rd_en = rd_en; v.ld = ld;
        v.jmp = jmp; v.ja = ja; v.hreq = hreq;
        v.eflags = ef; v.epc = epc; v.ecnt = ecnt;
        return v;
    endfunction

    function automatic vec_t idle(input logic hreq, input logic [5:0] ef,
                                  input logic [31:0] epc, input logic [CW-1:0] ecnt);
        return mk(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, hreq, ef, epc, ecnt);
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp_v);
        end
    endtask

    // Drive one cycle of inputs, compare at the falling edge, advance past the rising edge
    task automatic apply(input vec_t v, input string tag);
        de_rs1_addr  = v.rs1;  de_rs1_use = v.u1;
        de_rs2_addr  = v.rs2;  de_rs2_use = v.u2;
        ex_rd_addr   = v.rd;   ex_rd_en   = v.rd_en;  ex_is_load = v.ld;
        ex_jump_en   = v.jmp;  ex_jump_addr = v.ja;   halt_req = v.hreq;
        @(negedge clk);
        check({tag, ".pc_hold"},     {31'd0, pc_hold},     {31'd0, v.eflags[5]});
        check({tag, ".ifde_hold"},   {31'd0, ifde_hold},   {31'd0, v.eflags[4]});
        check({tag, ".ifde_flush"},  {31'd0, ifde_flush},  {31'd0, v.eflags[3]});
        check({tag, ".dealu_flush"}, {31'd0, dealu_flush}, {31'd0, v.eflags[2]});
        check({tag, ".redirect_en"}, {31'd0, redirect_en}, {31'd0, v.eflags[1]});
        check({tag, ".halted"},      {31'd0, halted},      {31'd0, v.eflags[0]});
        check({tag, ".stall_cnt"},   {28'd0, stall_cnt},   {28'd0, v.ecnt});
        if (v.eflags[1]) begin
            check({tag, ".redirect_pc"}, redirect_pc, v.epc);
        end
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[13];

    initial begin
        n_chk  = 0;
        n_fail = 0;

        // RUN-state vectors, applied back to back; ecnt is the count seen during that cycle
        tbl[0]  = idle(1'b0, F_NONE, 32'h0, 4'd0);
        tbl[1]  = mk(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, F_STALL, 32'h0, 4'd0);
        tbl[2]  = idle(1'b0, F_NONE, 32'h0, 4'd1);
        tbl[3]  = mk(5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, F_NONE, 32'h0, 4'd1);
        tbl[4]  = mk(5'd3, 1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, F_STALL, 32'h0, 4'd1);
        tbl[5]  = mk(5'd3, 1'b1, 5'd7, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, F_NONE, 32'h0, 4'd2);
        tbl[6]  = mk(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, F_NONE, 32'h0, 4'd2);
        tbl[7]  = mk(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, F_NONE, 32'h0, 4'd2);
        tbl[8]  = mk(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 32'h0000_0100, 1'b0, F_JUMP, 32'h0000_0100, 4'd2);
        tbl[9]  = idle(1'b0, F_NONE, 32'h0, 4'd2);
        tbl[10] = mk(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, F_JUMP, 32'hDEAD_BEEF, 4'd2);
        tbl[11] = mk(5'd9, 1'b1, 5'd9, 1'b1, 5'd9, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, F_STALL, 32'h0, 4'd2);
        tbl[12] = idle(1'b0, F_NONE, 32'h0, 4'd3);

        // Reset, then the first cycle carries the boot redirect
        rst = 1'b1;
        de_rs1_addr = 5'd0; de_rs1_use = 1'b0; de_rs2_addr = 5'd0; de_rs2_use = 1'b0;
        ex_rd_addr = 5'd0; ex_rd_en = 1'b0; ex_is_load = 1'b0;
        ex_jump_en = 1'b0; ex_jump_addr = 32'h0; halt_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        apply(idle(1'b0, F_RST, RST_PC_T, 4'd0), "reset");

        for (int i = 0; i < 13; i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // Halt without jump: 3 drain cycles, halted from t+4, plain resume
        apply(idle(1'b1, F_DRAIN, 32'h0, 4'd3), "hA.enter");
        apply(idle(1'b1, F_DRAIN, 32'h0, 4'd4), "hA.d1");
        apply(mk(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, F_DRAIN, 32'h0, 4'd4), "hA.d2luh");
        apply(idle(1'b1, F_DRAIN, 32'h0, 4'd4), "hA.d3");
        apply(idle(1'b1, F_HALT, 32'h0, 4'd4), "hA.h1");
        apply(idle(1'b1, F_HALT, 32'h0, 4'd4), "hA.h2");
        apply(idle(1'b0, F_HALT, 32'h0, 4'd4), "hA.release");
        apply(idle(1'b0, F_NONE, 32'h0, 4'd4), "hA.run");

        // Halt with a jump in the same cycle; halt_req drops mid-drain
        apply(mk(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 32'h0000_0200, 1'b1, F_DRAIN, 32'h0, 4'd4), "hB.enter");
        apply(idle(1'b0, F_DRAIN, 32'h0, 4'd5), "hB.d1");
        apply(mk(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 32'h0000_0999, 1'b0, F_DRAIN, 32'h0, 4'd5), "hB.d2jmp");
        apply(idle(1'b0, F_DRAIN, 32'h0, 4'd5), "hB.d3");
        apply(idle(1'b0, F_HREL, 32'h0000_0200, 4'd5), "hB.release");
        apply(idle(1'b0, F_NONE, 32'h0, 4'd5), "hB.run");

        // Reset during drain discards the pending jump and reissues the boot redirect
        apply(mk(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 32'h0000_0300, 1'b1, F_DRAIN, 32'h0, 4'd5), "hC.enter");
        apply(idle(1'b1, F_DRAIN, 32'h0, 4'd6), "hC.d1");
        rst = 1'b1;
        halt_req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        apply(idle(1'b0, F_RST, RST_PC_T, 4'd0), "hC.rst");
        apply(idle(1'b0, F_NONE, 32'h0, 4'd0), "hC.run");

        // Continuous load-use stalls wrap the counter
        for (int i = 0; i < 16; i++) begin
            apply(mk(5'd4, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, F_STALL, 32'h0, CW'(i)),
                  $sformatf("wrap%0d", i));
        end
        apply(idle(1'b0, F_NONE, 32'h0, 4'd0), "wrap.end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage core (ifu, de, alu, lsu, wb).
- Detects load-use hazards between the de and alu stages and stalls the front end for one cycle.
- Flushes the two younger stages on a taken jump/branch resolved in alu and redirects the PC.
- Runs a halt/drain/resume state machine driven by an external debug request.
- Sits beside the pipeline registers and drives their hold/flush inputs and the ifu redirect port.

Parameters:
DRAIN_CYCLES, 3, cycles to let alu/lsu/wb contents retire after fetch stops before reporting halted
RST_PC, 32'h0000_0000, redirect target reported on the first cycle after reset
CNT_W, 32, width of the stall-cycle performance counter

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
de_rs1_addr  in  5  rs1 index of instruction in de
de_rs1_use  in  1  de instruction reads rs1
de_rs2_addr  in  5  rs2 index of instruction in de
de_rs2_use  in  1  de instruction reads rs2
ex_rd_addr  in  5  rd of instruction in alu
ex_rd_en  in  1  alu instruction writes rd
ex_is_load  in  1  alu instruction is a load
ex_jump_en  in  1  alu resolved a taken jump/branch this cycle
ex_jump_addr  in  32  target of that jump
halt_req  in  1  level debug halt request
pc_hold  out  1  ifu keeps PC, rom_en deasserted
ifde_hold  out  1  ifu_de register keeps contents
ifde_flush  out  1  ifu_de loads a NOP (32'h0000_0013), pc 0
dealu_flush  out  1  de_alu loads a bubble (rd_reg_en=0)
redirect_en  out  1  ifu loads redirect_pc next edge
redirect_pc  out  32  new PC
halted  out  1  core fully drained and stopped
stall_cnt  out  CNT_W  count of cycles with pc_hold=1 while in RUN

Behaviour:
- Reset (rst=1 at edge): state=RUN, drain counter=0, pending_valid=0, stall_cnt=0, halted=0. All control outputs are 0 except redirect_en=1 and redirect_pc=RST_PC for exactly the first cycle after reset.
- All outputs are registered-state-derived combinational decodes: hazard outputs are same-cycle combinational from inputs plus state; no extra latency.
- Load-use hazard (luh): ex_is_load & ex_rd_en & ex_rd_addr!=0 & ((de_rs1_use & de_rs1_addr==ex_rd_addr) | (de_rs2_use & de_rs2_addr==ex_rd_addr)).
- Priority in RUN:
  1. ex_jump_en: redirect_en=1, redirect_pc=ex_jump_addr, ifde_flush=1, dealu_flush=1. luh is ignored because the de instruction is being flushed.
  2. luh: pc_hold=1, ifde_hold=1, dealu_flush=1. This lasts one cycle; the load then leaves alu and luh drops.
  3. Otherwise all outputs 0.
- Non-load RAW hazards are not handled here; forwarding is out of scope. A separate block owns that.
- State RUN -> DRAIN when halt_req=1. Same cycle: pc_hold=1, ifde_flush=1, dealu_flush=1. The instruction in de is discarded and is re-fetched on resume, so the PC is not advanced past it.
  - If ex_jump_en is set that cycle, the jump target is latched into pending_pc with pending_valid=1. Otherwise pending_pc=de PC equivalent, supplied as the held ifu PC, and pending_valid=0.
- State DRAIN: pc_hold=1, ifde_flush=1, dealu_flush=1 each cycle. Drain counter increments; on reaching DRAIN_CYCLES-1 the next state is HALTED. A halt_req drop during DRAIN does not abort the drain.
- State HALTED: halted=1, pc_hold=1, flushes held.
  - When halt_req=0: next state is RUN and the counter clears.
  - If pending_valid=1, that cycle also asserts redirect_en with redirect_pc=pending_pc, then clears pending_valid.
- ex_jump_en during DRAIN or HALTED is ignored; it cannot occur because bubbles are injected.
- stall_cnt increments by 1 on each RUN cycle with pc_hold=1 and wraps at 2^CNT_W. It does not count in DRAIN/HALTED.
- rst mid-DRAIN/HALTED returns to RUN immediately; pending redirect is discarded and the RST_PC redirect is issued.

Decomposition:
- Shared package core_pkg: NOP encoding 32'h0000_0013, x0 index, state encoding enum {RUN, DRAIN, HALTED}. This package is also used by ifu_de/de_alu for bubble values.
- Sub-module hazard_det: pure combinational luh comparator. Everything else is in pipe_ctrl.

Test Plan:
- lw x5,0(x1) in alu with add x6,x5,x2 in de -> pc_hold=ifde_hold=dealu_flush=1 for exactly 1 cycle; stall_cnt 0->1.
- Same as above but rd=x0 -> no stall, all outputs 0.
- ex_jump_en=1, ex_jump_addr=32'h100, luh also true -> redirect_en=1, redirect_pc=32'h100, ifde_flush=dealu_flush=1, pc_hold=0, stall_cnt unchanged.
- halt_req rises at cycle t with DRAIN_CYCLES=3 -> halted=1 from cycle t+4. halt_req falls -> state RUN, halted=0 next cycle, no redirect.
- halt_req and ex_jump_en(addr 32'h200) in the same cycle -> drain, halted. On release, a one-cycle redirect_en with redirect_pc=32'h200 is issued.
- rst asserted during DRAIN -> next cycle state RUN, halted=0, stall_cnt=0, redirect_en=1 with redirect_pc=RST_PC for one cycle only.
